// File: rtl/rice_bus_arbiter_if.sv
// Bus bundle between the two core masters, the arbiter and the shared rice bus slave port.
// Signal names follow the arbiter's point of view: i_* flow into the arbiter, o_* flow out of it.
interface rice_bus_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  // Master side: index 0 = instruction fetch, index 1 = load/store
  logic [1:0]                         i_m_request_valid;
  logic [1:0]                         o_m_request_ack;
  logic [1:0][ADDRESS_WIDTH-1:0]      i_m_address;
  logic [1:0][DATA_WIDTH/8-1:0]       i_m_strobe;
  logic [1:0][DATA_WIDTH-1:0]         i_m_write_data;
  logic [1:0]                         o_m_response_valid;
  logic [1:0]                         i_m_response_ready;
  logic [1:0][DATA_WIDTH-1:0]         o_m_read_data;

  // Shared slave port
  logic                               o_s_request_valid;
  logic                               i_s_request_ready;
  logic [ADDRESS_WIDTH-1:0]           o_s_address;
  logic [DATA_WIDTH/8-1:0]            o_s_strobe;
  logic [DATA_WIDTH-1:0]              o_s_write_data;
  logic                               i_s_response_valid;
  logic                               o_s_response_ready;
  logic [DATA_WIDTH-1:0]              i_s_read_data;

  // Arbiter view of the bundle
  modport slave (
    input  i_m_request_valid, i_m_address, i_m_strobe, i_m_write_data, i_m_response_ready,
    input  i_s_request_ready, i_s_response_valid, i_s_read_data,
    output o_m_request_ack, o_m_response_valid, o_m_read_data,
    output o_s_request_valid, o_s_address, o_s_strobe, o_s_write_data, o_s_response_ready
  );

  // Environment view: the masters and the slave that surround the arbiter
  modport master (
    output i_m_request_valid, i_m_address, i_m_strobe, i_m_write_data, i_m_response_ready,
    output i_s_request_ready, i_s_response_valid, i_s_read_data,
    input  o_m_request_ack, o_m_response_valid, o_m_read_data,
    input  o_s_request_valid, o_s_address, o_s_strobe, o_s_write_data, o_s_response_ready
  );
endinterface

// File: rtl/rice_bus_arbiter.sv
// 2:1 round-robin arbiter sharing one rice bus slave port between instruction fetch (M0)
// and load/store (M1). Requests are muxed from the granted master; responses are routed
// back in order by a small FIFO holding the index of each accepted master.
module rice_bus_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  rice_bus_arbiter_if.slave bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // OPEN: grant recomputed every cycle; LOCKED: a presented request waits for the slave
  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  arb_state_e                 state_q, state_d;
  logic                       lock_idx_q, lock_idx_d;
  logic                       prio_q, prio_d;
  logic [MAX_OUTSTANDING-1:0] fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [1:0] grant;
  logic       grant_idx;
  logic       grant_any;
  logic       fifo_full;
  logic       fifo_empty;
  logic       s_req_valid;
  logic       accept;
  logic       head_idx;
  logic       s_rsp_ready;
  logic       pop;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Grant selection: held grant while locked, otherwise single requester or pointer master
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned, which would infer a latch.
    grant = 2'b00;
    if (state_q == ARB_LOCKED) begin
      grant = lock_idx_q ? 2'b10 : 2'b01;
    end else begin
      unique case (bus.i_m_request_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_idx   = grant[1];
  assign grant_any   = |grant;
  // A full FIFO blocks new requests even when a response pops in the same cycle
  assign s_req_valid = (|(bus.i_m_request_valid & grant)) && !fifo_full && !i_rst;
  assign accept      = s_req_valid && bus.i_s_request_ready;

  assign bus.o_s_request_valid = s_req_valid;
  assign bus.o_s_address       = grant_any ? bus.i_m_address[grant_idx]    : '0;
  assign bus.o_s_strobe        = grant_any ? bus.i_m_strobe[grant_idx]     : '0;
  assign bus.o_s_write_data    = grant_any ? bus.i_m_write_data[grant_idx] : '0;
  assign bus.o_m_request_ack   = grant & {2{accept}};

  // Response routing follows the oldest outstanding request; nothing routes when empty
  assign head_idx    = fifo_mem_q[rd_ptr_q];
  assign s_rsp_ready = bus.i_m_response_ready[head_idx] && !fifo_empty && !i_rst;
  assign pop         = bus.i_s_response_valid && s_rsp_ready;

  assign bus.o_s_response_ready = s_rsp_ready;
  assign bus.o_m_response_valid =
    (bus.i_s_response_valid && !fifo_empty && !i_rst) ? (head_idx ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_m_read_data      = {2{bus.i_s_read_data}};

  // Lock and priority next state: lock a stalled grant, rotate priority on acceptance
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    prio_d     = prio_q;
    if (accept) begin
      state_d = ARB_OPEN;
      prio_d  = ~grant_idx;
    end else if (s_req_valid) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = grant_idx;
    end
  end

  // ID FIFO next state: push accepted master index, pop on completed response
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (accept) begin
      fifo_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= 1'b0;
      prio_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      prio_q     <= prio_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage register
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; entries are only read while count_q marks them valid.
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
